// File: rtl/tinydfu_pkg.sv
// Shared constants and types for the TinyDFU bootloader supervisor.
package tinydfu_pkg;

    localparam logic [7:0] DFU_IDLE       = 8'h02;
    localparam logic [7:0] DFU_ERROR      = 8'h0A;
    localparam logic [7:0] DFU_ACTIVE_MIN = 8'h03;

    typedef enum logic [1:0] {
        RESET_WAIT,
        AUTOBOOT,
        MANUAL,
        BOOT
    } boot_state_t;

    typedef enum logic [2:0] {
        LED_LAMP,
        LED_OFF,
        LED_ERROR,
        LED_IDLE,
        LED_CYLON
    } led_mode_t;

endpackage

// File: rtl/tinydfu_boot_ctrl_if.sv
// Link between usb_dfu_core (master) and the boot supervisor (slave).
interface tinydfu_boot_ctrl_if;

    logic [7:0] dfu_state;
    logic       dfu_detach;
    logic       usb_reset;
    logic       usb_pull_en;

    modport master (
        output dfu_state,
        output dfu_detach,
        input  usb_reset,
        input  usb_pull_en
    );

    modport slave (
        input  dfu_state,
        input  dfu_detach,
        output usb_reset,
        output usb_pull_en
    );

endinterface

// File: rtl/tinydfu_led_pattern.sv
// Status LED pattern generator: free-running counter, blink sources and a
// bouncing one-hot cylon advanced on synchronous edges of a counter bit.
module tinydfu_led_pattern
    import tinydfu_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 3,
    parameter int unsigned BLINK_BIT      = 21,
    parameter int unsigned STEP_BIT       = 20,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  led_mode_t           mode,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned TOP_BIT = (BLINK_BIT > STEP_BIT) ? BLINK_BIT : STEP_BIT;
    localparam int unsigned CW      = TOP_BIT + 1;
    localparam int unsigned PW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PW-1:0]       POS_MAX = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] POL     = {NUM_LEDS{LED_ACTIVE_LOW}};

    logic [CW-1:0]       cnt;
    logic                step_d;
    logic                step_rise;
    logic [PW-1:0]       pos;
    logic                dir_down;
    logic [NUM_LEDS-1:0] pat;

    assign step_rise = cnt[STEP_BIT] & ~step_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            step_d <= 1'b0;
        end else begin
            cnt    <= cnt + CW'(1);
            step_d <= cnt[STEP_BIT];
        end
    end

    // Position bounces 0 -> N-1 -> 0; a single LED never moves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos      <= '0;
            dir_down <= 1'b0;
        end else if (step_rise && (NUM_LEDS > 1)) begin
            if (dir_down) begin
                if (pos == '0) begin
                    dir_down <= 1'b0;
                    pos      <= PW'(1);
                end else begin
                    pos <= pos - PW'(1);
                end
            end else if (pos == POS_MAX) begin
                dir_down <= 1'b1;
                pos      <= POS_MAX - PW'(1);
            end else begin
                pos <= pos + PW'(1);
            end
        end
    end

    always_comb begin
        pat = '0;
        unique case (mode)
            LED_LAMP:  pat = '1;
            LED_OFF:   pat = '0;
            LED_ERROR: pat = {NUM_LEDS{cnt[BLINK_BIT]}};
            LED_IDLE:  pat[0] = cnt[BLINK_BIT];
            LED_CYLON: pat = NUM_LEDS'(1) << pos;
            default:   pat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) led <= '1 ^ POL;
        else         led <= pat ^ POL;
    end

endmodule

// File: rtl/tinydfu_boot_ctrl.sv
// Bootloader supervisor: USB reset/pull-up sequencing, autoboot countdown
// with cancel, sticky boot request and status LED mode selection.
module tinydfu_boot_ctrl
    import tinydfu_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 12000000,
    parameter int unsigned BOOT_TIMEOUT_S = 5,
    parameter int unsigned RESET_CYCLES   = 65535,
    parameter int unsigned NUM_LEDS       = 3,
    parameter int unsigned BLINK_BIT      = 21,
    parameter int unsigned STEP_BIT       = 20,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    tinydfu_boot_ctrl_if.slave  core,
    input  logic                btn,
    output logic                boot_now,
    output logic                auto_boot_active,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned BOOT_TICKS = CLK_HZ * BOOT_TIMEOUT_S;
    localparam int unsigned BOOT_W_RAW = $clog2(BOOT_TICKS + 1);
    localparam int unsigned BOOT_W     = (BOOT_W_RAW < 1) ? 1 : BOOT_W_RAW;
    localparam int unsigned RST_W_RAW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned RST_W      = (RST_W_RAW < 1) ? 1 : RST_W_RAW;
    localparam logic [BOOT_W-1:0] BOOT_LOAD =
        BOOT_W'((BOOT_TICKS == 32'd0) ? 32'd0 : BOOT_TICKS - 32'd1);
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_CYCLES);
    localparam bit                AUTOBOOT_EN = (BOOT_TIMEOUT_S != 0);

    boot_state_t       state;
    boot_state_t       state_nxt;
    logic [RST_W-1:0]  rst_cnt;
    logic [BOOT_W-1:0] boot_cnt;
    logic [1:0]        btn_sync;
    logic              btn_s;
    logic              usb_reset_q;
    logic              usb_pull_en_q;
    led_mode_t         led_mode_c;

    assign btn_s            = btn_sync[1];
    assign core.usb_reset   = usb_reset_q;
    assign core.usb_pull_en = usb_pull_en_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) btn_sync <= 2'b00;
        else         btn_sync <= {btn_sync[0], btn};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RESET_WAIT;
        else         state <= state_nxt;
    end

    // Cancel outranks expiry; detach outranks everything.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RESET_WAIT: begin
                if (rst_cnt == '0)
                    state_nxt = (btn_s || !AUTOBOOT_EN) ? MANUAL : AUTOBOOT;
            end
            AUTOBOOT: begin
                if (core.dfu_detach)
                    state_nxt = BOOT;
                else if ((core.dfu_state >= DFU_ACTIVE_MIN) || btn_s)
                    state_nxt = MANUAL;
                else if (boot_cnt == '0)
                    state_nxt = BOOT;
            end
            MANUAL: begin
                if (core.dfu_detach) state_nxt = BOOT;
            end
            BOOT:    state_nxt = BOOT;
            default: state_nxt = RESET_WAIT;
        endcase
    end

    // boot_cnt is preloaded while waiting so it is full on AUTOBOOT entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_cnt  <= RST_LOAD;
            boot_cnt <= BOOT_LOAD;
        end else if (state == RESET_WAIT) begin
            if (rst_cnt != '0) rst_cnt <= rst_cnt - RST_W'(1);
            boot_cnt <= BOOT_LOAD;
        end else if ((state == AUTOBOOT) && (boot_cnt != '0)) begin
            boot_cnt <= boot_cnt - BOOT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            usb_reset_q      <= 1'b1;
            usb_pull_en_q    <= 1'b0;
            boot_now         <= 1'b0;
            auto_boot_active <= 1'b0;
        end else begin
            usb_reset_q      <= (state_nxt == RESET_WAIT);
            usb_pull_en_q    <= (state_nxt != RESET_WAIT);
            boot_now         <= (state_nxt == BOOT);
            auto_boot_active <= (state_nxt == AUTOBOOT);
        end
    end

    always_comb begin
        led_mode_c = LED_CYLON;
        if (state_nxt == RESET_WAIT)         led_mode_c = LED_LAMP;
        else if (state_nxt == BOOT)          led_mode_c = LED_OFF;
        else if (core.dfu_state == DFU_ERROR) led_mode_c = LED_ERROR;
        else if (core.dfu_state == DFU_IDLE)  led_mode_c = LED_IDLE;
    end

    tinydfu_led_pattern #(
        .NUM_LEDS       (NUM_LEDS),
        .BLINK_BIT      (BLINK_BIT),
        .STEP_BIT       (STEP_BIT),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_led_pattern (
        .clk    (clk),
        .resetn (resetn),
        .mode   (led_mode_c),
        .led    (led)
    );

endmodule

// File: tb/tb_tinydfu_boot_ctrl.sv
// Scoreboard bench: stimulus queues expected output-change events, monitors
// pop and compare them (value and cycle stamp) whenever the outputs change.
module tb_tinydfu_boot_ctrl;

    logic       clk = 1'b0;
    logic       resetn0, resetn1;
    logic       btn0, btn1;
    logic       boot_now0, boot_now1;
    logic       aba0, aba1;
    logic [3:0] led0, led1;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    tinydfu_boot_ctrl_if if0 ();
    tinydfu_boot_ctrl_if if1 ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tinydfu_boot_ctrl #(
        .CLK_HZ(100), .BOOT_TIMEOUT_S(1), .RESET_CYCLES(8), .NUM_LEDS(4),
        .BLINK_BIT(3), .STEP_BIT(2), .LED_ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .resetn(resetn0), .core(if0.slave), .btn(btn0),
        .boot_now(boot_now0), .auto_boot_active(aba0), .led(led0)
    );

    tinydfu_boot_ctrl #(
        .CLK_HZ(100), .BOOT_TIMEOUT_S(0), .RESET_CYCLES(8), .NUM_LEDS(4),
        .BLINK_BIT(3), .STEP_BIT(2), .LED_ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk(clk), .resetn(resetn1), .core(if1.slave), .btn(btn1),
        .boot_now(boot_now1), .auto_boot_active(aba1), .led(led1)
    );

    // Control outputs per DUT: {usb_reset, usb_pull_en, boot_now, auto_boot_active}
    typedef struct {
        logic [7:0] val;
        int         at;
    } ctl_exp_t;

    typedef struct {
        logic [3:0] val;
        int         gap;
    } led_exp_t;

    ctl_exp_t ctl_q[$];
    led_exp_t led_q[$];

    logic [7:0] ctl_prev;
    bit         ctl_seen = 0;
    bit         led_en = 0;
    bit         led_seen = 0;
    logic [3:0] led_prev;
    int         led_last = 0;

    always @(negedge clk) begin
        logic [7:0] obs;
        ctl_exp_t   e;
        obs = {if0.usb_reset, if0.usb_pull_en, boot_now0, aba0,
               if1.usb_reset, if1.usb_pull_en, boot_now1, aba1};
        if (!ctl_seen || obs !== ctl_prev) begin
            ctl_seen = 1;
            ctl_prev = obs;
            vectors++;
            if (ctl_q.size() == 0) begin
                miscompares++;
                $display("FAIL ctl_unexpected cyc=%0d got=%b want=no change", cyc, obs);
            end else begin
                e = ctl_q.pop_front();
                if (obs !== e.val || (e.at >= 0 && cyc != e.at)) begin
                    miscompares++;
                    $display("FAIL ctl_event got=%b@%0d want=%b@%0d", obs, cyc, e.val, e.at);
                end
            end
        end
    end

    always @(negedge clk) begin
        led_exp_t e;
        int       gap;
        if (led_en && (!led_seen || led0 !== led_prev)) begin
            gap      = cyc - led_last;
            led_last = cyc;
            led_prev = led0;
            vectors++;
            if (led_q.size() == 0) begin
                miscompares++;
                $display("FAIL led_unexpected cyc=%0d got=%b", cyc, led0);
            end else begin
                e = led_q.pop_front();
                if (led0 !== e.val || (led_seen && e.gap != 0 && gap != e.gap)) begin
                    miscompares++;
                    $display("FAIL led_event got=%b gap=%0d want=%b gap=%0d",
                             led0, gap, e.val, e.gap);
                end
            end
            led_seen = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ctl(input logic [3:0] e0, input logic [3:0] e1, input int at);
        ctl_q.push_back('{val: {e0, e1}, at: at});
    endtask

    task automatic push_led(input logic [3:0] v, input int gap);
        led_q.push_back('{val: v, gap: gap});
    endtask

    task automatic wait_led(input logic [3:0] v, input int limit, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led0 !== v && n < limit);
        vectors++;
        if (led0 !== v) begin
            miscompares++;
            $display("FAIL %s timeout led=%b want=%b", nm, led0, v);
        end
    endtask

    // Arm the led monitor on a value just observed at this negedge.
    task automatic arm_led_here();
        led_last = cyc;
        led_prev = led0;
        led_seen = 1;
        led_en   = 1;
    endtask

    task automatic led_drain(input string nm);
        led_en = 0;
        vectors++;
        if (led_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s led events missing: %0d left want 0", nm, led_q.size());
        end
        led_q.delete();
    endtask

    initial begin
        int c0;
        int d;
        resetn0 = 1'b0;  resetn1 = 1'b0;
        btn0 = 1'b0;     btn1 = 1'b0;
        if0.dfu_state = 8'h02; if0.dfu_detach = 1'b0;
        if1.dfu_state = 8'h02; if1.dfu_detach = 1'b0;
        push_ctl(4'b1000, 4'b1000, -1);

        // Reset release, 9-edge USB reset, autoboot after 100 cycles
        tick(3);
        c0 = cyc;
        push_ctl(4'b0101, 4'b1000, c0 + 9);
        push_ctl(4'b0110, 4'b1000, c0 + 109);
        resetn0 = 1'b1;
        tick(120);

        // Reset asserted while in BOOT: immediate lamp test and USB reset
        led_seen = 0;
        push_led(4'b0000, 0);
        push_led(4'b1111, 0);
        led_en = 1;
        tick(2);
        push_ctl(4'b1000, 4'b1000, cyc);
        resetn0 = 1'b0;
        tick(3);
        led_drain("boot_reset");

        // Cancel by DFU activity at cycle 40, then cylon/error LEDs, then detach
        c0 = cyc;
        push_ctl(4'b0101, 4'b1000, c0 + 9);
        resetn0 = 1'b1;
        tick(49);
        push_ctl(4'b0100, 4'b1000, c0 + 50);
        if0.dfu_state = 8'h05;
        tick(1);
        wait_led(4'b0010, 100, "cylon_sync_a");
        wait_led(4'b0001, 100, "cylon_sync_b");
        push_led(4'b0010, 8); push_led(4'b0100, 8); push_led(4'b1000, 8);
        push_led(4'b0100, 8); push_led(4'b0010, 8); push_led(4'b0001, 8);
        arm_led_here();
        tick(52);
        led_drain("cylon");
        if0.dfu_state = 8'h0A;
        wait_led(4'b0000, 40, "err_sync_a");
        wait_led(4'b1111, 40, "err_sync_b");
        push_led(4'b0000, 8); push_led(4'b1111, 8); push_led(4'b0000, 8);
        arm_led_here();
        tick(28);
        led_drain("error_blink");
        if0.dfu_state = 8'h05;
        while (cyc < c0 + 50 + 520) tick(1);
        d = cyc;
        push_ctl(4'b0110, 4'b1000, d + 1);
        if0.dfu_detach = 1'b1;
        tick(1);
        if0.dfu_detach = 1'b0;
        tick(5);

        // Button held through RESET_WAIT goes straight to MANUAL
        push_ctl(4'b1000, 4'b1000, cyc);
        resetn0 = 1'b0;
        btn0 = 1'b1;
        if0.dfu_state = 8'h02;
        tick(3);
        c0 = cyc;
        push_ctl(4'b0100, 4'b1000, c0 + 9);
        resetn0 = 1'b1;
        tick(30);
        btn0 = 1'b0;
        tick(150);

        // Cancel on the very cycle the countdown reaches zero
        push_ctl(4'b1000, 4'b1000, cyc);
        resetn0 = 1'b0;
        tick(3);
        c0 = cyc;
        push_ctl(4'b0101, 4'b1000, c0 + 9);
        resetn0 = 1'b1;
        tick(108);
        push_ctl(4'b0100, 4'b1000, c0 + 109);
        if0.dfu_state = 8'h05;
        tick(200);

        // Autoboot disabled: MANUAL after reset, boot only on detach
        c0 = cyc;
        push_ctl(4'b0100, 4'b0100, c0 + 9);
        resetn1 = 1'b1;
        tick(300);
        d = cyc;
        push_ctl(4'b0100, 4'b0110, d + 1);
        if1.dfu_detach = 1'b1;
        tick(1);
        if1.dfu_detach = 1'b0;
        tick(5);
        vectors++;
        if (led1 !== 4'b0000) begin
            miscompares++;
            $display("FAIL no_timeout_boot_led got=%b want=0000", led1);
        end

        vectors++;
        if (ctl_q.size() != 0) begin
            miscompares++;
            $display("FAIL ctl events missing: %0d left want 0", ctl_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
